uart_rx: RTL

Serial receiver stage of the UART: oversamples the asynchronous `rx` line at 16× the baud rate, recovers 8N1 frames (start, DATALEN data bits LSB-first, one stop bit), and presents each byte as `rx_data` with a single-cycle `rx_done` strobe. It sits directly upstream of the RX FIFO. `rx_done` drives the FIFO push and `rx_data` drives its write data. Framing errors are flagged and never pushed.

---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with 16x oversampling.
//
// Recovers start / DATALEN data bits (LSB first) / one stop bit frames from
// an asynchronous, idle-high serial line and presents each good byte with a
// single-cycle strobe suitable for driving a FIFO push directly.
//
// Parameters:
//   CLK_FREQ  system clock in Hz
//   BAUD      line rate in bit/s; CLK_FREQ/(BAUD*16) must be >= 2
//   DATALEN   data bits per frame (>= 2)
//
// Ports:
//   clk        system clock, rising edge active
//   rst        asynchronous reset, active low
//   rx         serial input, asynchronous to clk, idle high
//   rx_data    last correctly received byte, held until the next rx_done
//   rx_done    one-cycle pulse when rx_data is updated with a valid frame
//   rx_busy    high from start-bit detection until return to idle
//   frame_err  one-cycle pulse when the stop bit is sampled low
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DATALEN  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [DATALEN-1:0] rx_data,
  output logic               rx_done,
  output logic               rx_busy,
  output logic               frame_err
);

  localparam int DIV    = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCNT_W = (DATALEN > 1) ? $clog2(DATALEN) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATALEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               w_rx_s;
  logic [DIV_W-1:0]   r_div;
  logic               w_tick;
  state_t             r_state;
  logic [3:0]         r_scnt;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [DATALEN-1:0] r_shift;

  assign w_rx_s = r_sync2;
  assign w_tick = (r_div == DIV_LAST);

  // Two-flop synchronizer; both stages reset high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running 16x oversample divider; not realigned to frames, so phase error is <= 1 tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Receive FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_scnt    <= 4'd0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_scnt  <= 4'd0;
            r_state <= S_START;
            rx_busy <= 1'b1;
          end
        end
        S_START: begin
          // Re-check the line in the middle of the start bit to reject glitches.
          if (w_tick) begin
            if (r_scnt == 4'd7) begin
              if (w_rx_s) begin
                r_state <= S_IDLE;
                rx_busy <= 1'b0;
              end else begin
                r_scnt  <= 4'd0;
                r_bcnt  <= '0;
                r_state <= S_DATA;
              end
            end else begin
              r_scnt <= r_scnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          // From mid start bit, 16 ticks land in the middle of each data bit.
          if (w_tick) begin
            if (r_scnt == 4'd15) begin
              r_shift <= {w_rx_s, r_shift[DATALEN-1:1]};
              r_scnt  <= 4'd0;
              if (r_bcnt == BCNT_LAST) begin
                r_state <= S_STOP;
              end else begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
              end
            end else begin
              r_scnt <= r_scnt + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_scnt == 4'd15) begin
              r_scnt <= 4'd0;
              if (w_rx_s) begin
                rx_data <= r_shift;
                rx_done <= 1'b1;
                r_state <= S_IDLE;
                rx_busy <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                r_state   <= S_BREAK;
              end
            end else begin
              r_scnt <= r_scnt + 4'd1;
            end
          end
        end
        S_BREAK: begin
          // A held-low line must return high before another start is accepted.
          if (w_rx_s) begin
            r_state <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
